// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, the load
// result-source code and the cache-wait FSM states.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF         = 2'b00;
  localparam logic [1:0] FWD_W          = 2'b01;
  localparam logic [1:0] FWD_M          = 2'b10;
  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  // M-stage match wins over W-stage match; the caller has already excluded x0.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline stage blocks (master) and the hazard controller
// (slave). Level signals only; mem_state exposes the cache-wait FSM for debug.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]            ResultSrcE;
  logic                  PCSrcE, RegwriteM, RegwriteW, CacheWait;

  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE;
  logic                  MemTimeout;
  logic [CNT_W-1:0]      StallCycles, FlushCount;
  wait_state_t           mem_state;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           PCSrcE, RegwriteM, RegwriteW, CacheWait,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemTimeout, StallCycles, FlushCount, mem_state
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           PCSrcE, RegwriteM, RegwriteW, CacheWait,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemTimeout, StallCycles, FlushCount, mem_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Cache-wait tracker: IDLE/WAIT state, saturating wait counter and the sticky
// MemTimeout watchdog flag. WAIT_TIMEOUT must be at least 2.
module pipeline_hazard_ctrl_mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_wait,
  output wait_state_t state,
  output logic        mem_wait,
  output logic        mem_timeout
);

  localparam int            CW       = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  wait_state_t   state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout | timeout_hit;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (cache_wait) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cache_wait) begin
          wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_ONE;
        end else begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // The stall follows CacheWait in the same cycle, so the first miss cycle in
  // IDLE already holds the pipeline.
  always_comb begin
    mem_wait    = cache_wait | ((state == ST_WAIT) & cache_wait);
    timeout_hit = (state == ST_WAIT) && cache_wait && (wait_cnt == CNT_LAST);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: E-stage forwarding, load-use interlock, branch flush,
// cache-wait stall with watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  logic             mem_wait, mem_timeout;
  logic             lu_hit, br_act, lu_act;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall_fd, stall_em, flush_d, flush_e;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl_mem_wait_fsm #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .cache_wait  (hz.CacheWait),
    .state       (hz.mem_state),
    .mem_wait    (mem_wait),
    .mem_timeout (mem_timeout)
  );

  always_comb begin
    fwd_a = fwd_sel(hz.RegwriteM && hz.RdM != REG_ZERO && hz.RdM == hz.Rs1E,
                    hz.RegwriteW && hz.RdW != REG_ZERO && hz.RdW == hz.Rs1E);
    fwd_b = fwd_sel(hz.RegwriteM && hz.RdM != REG_ZERO && hz.RdM == hz.Rs2E,
                    hz.RegwriteW && hz.RdW != REG_ZERO && hz.RdW == hz.Rs2E);
  end

  // Priority MEMWAIT > BR > LU. A branch held under MEMWAIT is still asserted
  // on PCSrcE when the miss clears, so it flushes on the release cycle.
  always_comb begin
    lu_hit   = (hz.ResultSrcE == RESULTSRC_LOAD) && (hz.RdE != REG_ZERO) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    br_act   = hz.PCSrcE && !mem_wait;
    lu_act   = lu_hit && !br_act && !mem_wait;
    stall_fd = rst & (mem_wait | lu_act);
    stall_em = rst & mem_wait;
    flush_d  = rst & br_act;
    flush_e  = rst & (br_act | lu_act);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_fd && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_d && flush_count != '1)   flush_count  <= flush_count + CNT_ONE;
    end
  end

  // Outputs are forced low while reset is asserted, even during a miss.
  always_comb begin
    hz.ForwardAE   = rst ? fwd_a : FWD_RF;
    hz.ForwardBE   = rst ? fwd_b : FWD_RF;
    hz.StallF      = stall_fd;
    hz.StallD      = stall_fd;
    hz.StallE      = stall_em;
    hz.StallM      = stall_em;
    hz.FlushD      = flush_d;
    hz.FlushE      = flush_e;
    hz.MemTimeout  = mem_timeout;
    hz.StallCycles = stall_cycles;
    hz.FlushCount  = flush_count;
  end

endmodule
